custom_pio_port: RTL and testbench
==================================

# custom_pio_port

Per-CPU Avalon-MM slave parallel port that drives and samples one bidirectional 8-bit conduit of the dual-CPU system. It is used as `cpu_0_custompio_0`, `cpu_1_custompio_0` and `shared_pio_output`. It sits directly between the Nios II data master (via the interconnect) and the board pins. It provides:
- per-bit direction control
- atomic set/clear of the output latch
- synchronised pin readback
- rising-edge capture with an interrupt

## Interface
Parameters:
- `WIDTH`, 8, port width in bits (1..32).
- `RESET_DIR`, 0, reset value of the direction register (1 = output).
- `RESET_PORT`, 0, reset value of the output latch.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. Release is synchronised externally by the interconnect reset controller.
- `address`  in  3  word address.
- `chipselect`  in  1  slave select; qualifies `read` and `write`.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `writedata`  in  32  write data; only bits `[WIDTH-1:0]` are used.
- `readdata`  out  32  read data, registered; upper bits are 0.
- `irq`  out  1  level interrupt, registered.
- `parport`  inout  `WIDTH`  pins; bit i is driven with `port[i]` when `dir[i]` = 1, otherwise high-Z.

## Operation
Register map (word addresses):
- 0 `DIR`: RW.
- 1 `PIN`: RO; the synchronised pin value. Output bits read back their own driven value through the pad.
- 2 `PORT`: RW output latch.
- 3 `SET`: WO; `port <= port | wd`. Reads return 0.
- 4 `CLR`: WO; `port <= port & ~wd`. Reads return 0.
- 5 `IRQ_MASK`: RW.
- 6 `EDGE_CAP`: reads the capture bits; writing 1 to a bit clears it (W1C).
- 7: reserved. Reads return 0; writes are ignored.

Input path:
- Two-flop synchroniser `s1`→`s2` on `parport`.
- Third flop `s3` holds the previous sample.
- A rising edge on bit i is `s2[i] & ~s3[i]`.
- Edges are detected on all bits regardless of `DIR`.

Edge capture:
- A detected edge sets `cap[i]`.
- If an edge and a W1C of the same bit occur in the same cycle, the set wins and the bit stays 1.

Interrupt:
- `irq` is registered: `irq <= |(cap & mask)`.
- It deasserts the cycle after the last enabled capture bit is cleared or masked.

Bus accesses:
- Accesses without `chipselect` are ignored.
- `read` and `write` asserted together: the write is performed and `readdata` returns the pre-write value.

Reset values:
- `dir` = `RESET_DIR`, `port` = `RESET_PORT`.
- `mask`, `cap`, `s1`, `s2`, `s3` are all 0.
- `readdata` = 0, `irq` = 0, all pins high-Z when `RESET_DIR` = 0.
- Reset asserted mid-operation returns everything to these values immediately (asynchronous). Any edge in flight is lost.

## Timing
- Write latency 0 wait states. A register updates on the clock edge on which `chipselect & write` is sampled, and a pin drives the new value from the next cycle.
- Read latency 1: `readdata` is valid on the cycle after `chipselect & read` and holds until the next read. Configure the interconnect with `readLatency` = 1 and no `waitrequest`.
- Pin-to-`PIN` latency: 2 cycles. Pin-to-`cap`: 3 cycles. Pin-to-`irq`: 4 cycles.
- Back-to-back `SET` and `CLR` writes on consecutive cycles apply in order, one per cycle.
- A pulse shorter than one `clk` period may be missed; this is not a defect.

## Configuration
- `CUSTOMPIO_IRQ_EN` defined:
  - `IRQ_MASK`, `EDGE_CAP`, `s3` and the `irq` logic are present as described above.
- Not defined:
  - Addresses 5 and 6 behave as reserved (read 0, writes ignored).
  - `irq` is tied to 0.
  - `s3` and the capture logic are not generated.
  - All other behaviour is unchanged.

## Test plan
- Reset with `RESET_DIR`=0, `RESET_PORT`=0 -> `parport` is all Z, `readdata`=0, `irq`=0. Read `DIR` -> 0x00.
- Write `DIR`=0xF0, `PORT`=0xA5 -> `parport[7:4]`=0xA drives from the next cycle, the low nibble stays Z. Read `PORT` -> 0xA5 one cycle after `read`.
- `PORT`=0x0F, then `SET` 0x30, then `CLR` 0x05 on consecutive cycles -> `PORT` reads 0x3A. Reads of `SET` and `CLR` return 0.
- Drive external pin 2 0→1 at cycle T, `mask`=0x04 -> `PIN[2]`=1 at T+2, `cap`=0x04 at T+3, `irq`=1 at T+4. W1C 0x04 -> `irq`=0 two cycles later.
- W1C of bit 2 in the same cycle as a new rising edge on bit 2 -> `cap[2]` remains 1 and `irq` stays high.
- Assert `reset_n` low mid-burst with `cap`=0xFF and `irq`=1 -> `irq`, `cap` and `readdata` are 0 in the same cycle. Build without `CUSTOMPIO_IRQ_EN` -> address 6 reads 0 and `irq` is never 1.

Source files
------------

// File: rtl/custom_pio_port.sv
// custom_pio_port: Avalon-MM slave parallel port driving one bidirectional
// conduit with per-bit direction, atomic set/clear of the output latch,
// synchronised pin readback and optional rising-edge capture with interrupt.
// Optional feature macro: CUSTOMPIO_IRQ_EN (adds IRQ_MASK, EDGE_CAP, s3, irq).
module custom_pio_port #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DIR  = '0,
  parameter logic [WIDTH-1:0] RESET_PORT = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] parport
);

  localparam logic [2:0] ADDR_DIR  = 3'd0;
  localparam logic [2:0] ADDR_PIN  = 3'd1;
  localparam logic [2:0] ADDR_PORT = 3'd2;
  localparam logic [2:0] ADDR_SET  = 3'd3;
  localparam logic [2:0] ADDR_CLR  = 3'd4;
`ifdef CUSTOMPIO_IRQ_EN
  localparam logic [2:0] ADDR_MASK = 3'd5;
  localparam logic [2:0] ADDR_CAP  = 3'd6;
`endif

  logic             wrEn;
  logic             rdEn;
  logic [WIDTH-1:0] wd;
  logic             unused_writedata;

  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] port_q, port_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [31:0]      readdata_q, readdata_d;

`ifdef CUSTOMPIO_IRQ_EN
  logic [WIDTH-1:0] s3_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] riseEdge;
  logic             irq_q;
`endif

  assign wrEn             = chipselect & write;
  assign rdEn             = chipselect & read;
  assign wd               = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;
  assign readdata         = readdata_q;

`ifdef CUSTOMPIO_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Each pin is driven from the output latch only while its direction bit is set
  for (genvar i = 0; i < WIDTH; i++) begin : gPad
    assign parport[i] = dir_q[i] ? port_q[i] : 1'bz;
  end

  // Next-state for writable registers, edge capture and the read-data mux
  always_comb begin
    dir_d      = dir_q;
    port_d     = port_q;
    readdata_d = readdata_q;
`ifdef CUSTOMPIO_IRQ_EN
    mask_d   = mask_q;
    w1c      = '0;
    riseEdge = s2_q & ~s3_q;
`endif
    if (wrEn) begin
      case (address)
        ADDR_DIR:  dir_d  = wd;
        ADDR_PORT: port_d = wd;
        ADDR_SET:  port_d = port_q | wd;
        ADDR_CLR:  port_d = port_q & ~wd;
`ifdef CUSTOMPIO_IRQ_EN
        ADDR_MASK: mask_d = wd;
        ADDR_CAP:  w1c    = wd;
`endif
        default:   ;
      endcase
    end
`ifdef CUSTOMPIO_IRQ_EN
    cap_d = (cap_q & ~w1c) | riseEdge;
`endif
    if (rdEn) begin
      case (address)
        ADDR_DIR:  readdata_d = 32'(dir_q);
        ADDR_PIN:  readdata_d = 32'(s2_q);
        ADDR_PORT: readdata_d = 32'(port_q);
`ifdef CUSTOMPIO_IRQ_EN
        ADDR_MASK: readdata_d = 32'(mask_q);
        ADDR_CAP:  readdata_d = 32'(cap_q);
`endif
        default:   readdata_d = 32'd0;
      endcase
    end
  end

  // State registers, pin synchroniser and registered bus/interrupt outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q      <= RESET_DIR;
      port_q     <= RESET_PORT;
      s1_q       <= '0;
      s2_q       <= '0;
      readdata_q <= 32'd0;
`ifdef CUSTOMPIO_IRQ_EN
      s3_q   <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
`endif
    end else begin
      dir_q      <= dir_d;
      port_q     <= port_d;
      s1_q       <= parport;
      s2_q       <= s1_q;
      readdata_q <= readdata_d;
`ifdef CUSTOMPIO_IRQ_EN
      s3_q   <= s2_q;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      irq_q  <= |(cap_q & mask_q);
`endif
    end
  end

endmodule

// File: tb/tb_custom_pio_port.sv
// tb_custom_pio_port: directed self-checking bench for custom_pio_port
// (WIDTH=8, RESET_DIR=0, RESET_PORT=0). Covers the CUSTOMPIO_IRQ_EN build
// when that macro is defined and the reserved-address behaviour otherwise.
module tb_custom_pio_port;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  wire  [7:0]  parport;

  logic [7:0]  extDrive;
  logic [7:0]  extEn;
  logic [31:0] rdVal;

  int checkCount = 0;
  int errorCount = 0;

  custom_pio_port #(
    .WIDTH(8),
    .RESET_DIR(8'h00),
    .RESET_PORT(8'h00)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .parport(parport)
  );

  // Board-side drivers for the pins the DUT leaves as inputs
  for (genvar i = 0; i < 8; i++) begin : gExt
    assign parport[i] = extEn[i] ? extDrive[i] : 1'bz;
  end

  // Free-running system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and log a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Single-cycle write; called at a negedge, returns at the following negedge
  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    chipselect = 1'b1;
    write      = 1'b1;
    read       = 1'b0;
    address    = addr;
    writedata  = data;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  // Single-cycle read; readdata is sampled one cycle after the strobe
  task automatic applyRead(input logic [2:0] addr, output logic [31:0] data);
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    address    = addr;
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    data       = readdata;
  endtask

  // Simultaneous read and write of the same address
  task automatic applyWriteRead(input logic [2:0] addr, input logic [31:0] data, output logic [31:0] rdata);
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    address    = addr;
    writedata  = data;
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    rdata      = readdata;
  endtask

  // Directed test sequence
  initial begin
    reset_n    = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 32'd0;
    extDrive   = 8'h00;
    extEn      = 8'h0F;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset readdata", readdata, 32'd0);
    checkOutput("reset irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    applyRead(3'd0, rdVal);
    checkOutput("DIR after reset", rdVal, 32'h00);

    applyStimulus(3'd0, 32'hF0);
    applyStimulus(3'd2, 32'hA5);
    checkOutput("pins 7:4 driven", {28'd0, parport[7:4]}, 32'hA);
    applyRead(3'd2, rdVal);
    checkOutput("PORT readback", rdVal, 32'hA5);

    extDrive = 8'h03;
    repeat (3) @(negedge clk);
    applyRead(3'd1, rdVal);
    checkOutput("PIN mixed", rdVal, 32'hA3);

    applyStimulus(3'd2, 32'h0F);
    applyStimulus(3'd3, 32'h30);
    applyStimulus(3'd4, 32'h05);
    applyRead(3'd2, rdVal);
    checkOutput("PORT set/clr", rdVal, 32'h3A);
    checkOutput("pins after set/clr", {28'd0, parport[7:4]}, 32'h3);
    applyRead(3'd3, rdVal);
    checkOutput("SET reads 0", rdVal, 32'd0);
    applyRead(3'd4, rdVal);
    checkOutput("CLR reads 0", rdVal, 32'd0);

    applyWriteRead(3'd2, 32'h55, rdVal);
    checkOutput("rw pre-write value", rdVal, 32'h3A);
    applyRead(3'd2, rdVal);
    checkOutput("rw post-write value", rdVal, 32'h55);

    applyStimulus(3'd7, 32'hFF);
    applyRead(3'd7, rdVal);
    checkOutput("reserved reads 0", rdVal, 32'd0);
    applyRead(3'd2, rdVal);
    checkOutput("reserved write ignored", rdVal, 32'h55);

`ifdef CUSTOMPIO_IRQ_EN
    applyStimulus(3'd6, 32'hFF);
    applyStimulus(3'd5, 32'h04);
    applyRead(3'd5, rdVal);
    checkOutput("MASK readback", rdVal, 32'h04);
    applyRead(3'd6, rdVal);
    checkOutput("CAP cleared", rdVal, 32'h00);
    checkOutput("irq idle", {31'd0, irq}, 32'd0);

    extDrive = 8'h07;
    repeat (3) @(negedge clk);
    checkOutput("irq T+3", {31'd0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq T+4", {31'd0, irq}, 32'd1);
    applyStimulus(3'd6, 32'h04);
    checkOutput("irq after W1C edge", {31'd0, irq}, 32'd1);
    @(negedge clk);
    checkOutput("irq cleared", {31'd0, irq}, 32'd0);

    extDrive = 8'h03;
    repeat (4) @(negedge clk);
    extDrive = 8'h07;
    repeat (2) @(negedge clk);
    applyStimulus(3'd6, 32'h04);
    applyRead(3'd6, rdVal);
    checkOutput("set wins over W1C", rdVal, 32'h04);
    checkOutput("irq stays high", {31'd0, irq}, 32'd1);

    applyStimulus(3'd5, 32'h00);
    checkOutput("irq mask edge", {31'd0, irq}, 32'd1);
    @(negedge clk);
    checkOutput("irq masked", {31'd0, irq}, 32'd0);
    applyStimulus(3'd5, 32'h04);
    @(negedge clk);
    checkOutput("irq unmasked", {31'd0, irq}, 32'd1);
`else
    applyStimulus(3'd5, 32'hFF);
    applyStimulus(3'd6, 32'hFF);
    applyRead(3'd5, rdVal);
    checkOutput("addr5 reserved", rdVal, 32'd0);
    applyRead(3'd6, rdVal);
    checkOutput("addr6 reserved", rdVal, 32'd0);
    extDrive = 8'h07;
    repeat (5) @(negedge clk);
    checkOutput("irq tied low", {31'd0, irq}, 32'd0);
`endif

    extDrive = 8'h00;
    applyRead(3'd2, rdVal);
    checkOutput("readdata before reset", rdVal, 32'h55);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async reset irq", {31'd0, irq}, 32'd0);
    checkOutput("async reset readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyRead(3'd6, rdVal);
    checkOutput("CAP after reset", rdVal, 32'd0);
    applyRead(3'd0, rdVal);
    checkOutput("DIR after mid reset", rdVal, 32'd0);
    applyRead(3'd2, rdVal);
    checkOutput("PORT after mid reset", rdVal, 32'd0);
    checkOutput("irq after mid reset", {31'd0, irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
